// File: rtl/uart_tty_core.sv
// Parametrised UART core: valid/ready transmitter, mid-bit sampling receiver,
// show-ahead RX FIFO and sticky receive error flags.
module uart_tty_core #(
  parameter int unsigned CLK_HZ        = 25000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter logic [1:0]  STOP_BITS     = 2'd1,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             uart_rx,
  output logic                             uart_tx,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic [DATA_BITS-1:0]             tx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
  input  logic                             err_clr,
  output logic                             rx_frame_err,
  output logic                             rx_parity_err,
  output logic                             rx_overrun
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned AW  = $clog2(RX_FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(DIV / 2 - 1);
  localparam logic [3:0]    LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_SBIT = {2'b00, STOP_BITS} - 4'd1;
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   FIFO_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(RX_FIFO_DEPTH);

  if ((DIV < 4) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY > 2) ||
      (STOP_BITS < 2'd1) || (STOP_BITS > 2'd2) || (RX_FIFO_DEPTH < 2) ||
      ((RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0)) begin : g_param_err
    $error("uart_tty_core: illegal parameter set");
  end

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_tick_s;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_push_q, rx_push_d;
  logic                 rx_tick_s, ferr_set_s;

  logic [DATA_BITS-1:0] fifo_q [RX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 pop_s, wr_en_s, full_s, ovr_set_s;
  logic                 ferr_q, ferr_d, perr_flag_q, perr_flag_d, ovr_q, ovr_d;

  // Transmit FSM: one down-counted bit period per state step.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_ready_d = tx_ready_q;
    tx_tick_s  = (tx_cnt_q == CNT_ZERO);
    tx_cnt_d   = tx_tick_s ? DIV_M1 : (tx_cnt_q - CNT_ONE);
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          tx_state_d = TX_START;
          tx_cnt_d   = DIV_M1;
          tx_shift_d = tx_data;
          tx_par_d   = parity_bit(tx_data, ODD);
          tx_line_d  = 1'b0;
          tx_ready_d = 1'b0;
        end else begin
          tx_line_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tick_s) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 4'd0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_tick_s && (tx_bit_q == LAST_DBIT)) begin
          tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
          tx_bit_d   = 4'd0;
          tx_line_d  = HAS_PAR ? tx_par_q : 1'b1;
        end else if (tx_tick_s) begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_tick_s) begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end else begin
          tx_state_d = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_tick_s && (tx_bit_q == LAST_SBIT)) begin
          tx_state_d = TX_IDLE;
          tx_ready_d = 1'b1;
        end else if (tx_tick_s) begin
          tx_bit_d   = tx_bit_q + 4'd1;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  // Receive FSM: half-period delay to the start-bit centre, then full periods.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push_d  = 1'b0;
    ferr_set_s = 1'b0;
    rx_tick_s  = (rx_cnt_q == CNT_ZERO);
    rx_cnt_d   = rx_tick_s ? DIV_M1 : (rx_cnt_q - CNT_ONE);
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_tick_s && rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else if (rx_tick_s) begin
          rx_state_d = RX_DATA;
          rx_bit_d   = 4'd0;
          rx_perr_d  = 1'b0;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_tick_s) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_DBIT) begin
            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
            rx_bit_d   = 4'd0;
          end else begin
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_tick_s) begin
          rx_state_d = RX_STOP;
          rx_perr_d  = rx_sync_q ^ parity_bit(rx_shift_q, ODD);
        end else begin
          rx_state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_tick_s && !rx_sync_q) begin
          rx_state_d = RX_BREAK;
          ferr_set_s = 1'b1;
        end else if (rx_tick_s && (rx_bit_q == LAST_SBIT)) begin
          rx_state_d = RX_IDLE;
          rx_push_d  = 1'b1;
        end else if (rx_tick_s) begin
          rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      RX_BREAK: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_BREAK;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push lands in.
  always_comb begin
    pop_s       = rx_valid_q && rx_ready;
    full_s      = (count_q == FIFO_FULL);
    wr_en_s     = rx_push_q && (!full_s || pop_s);
    ovr_set_s   = rx_push_q && full_s && !pop_s;
    wr_ptr_d    = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (wr_en_s && !pop_s) begin
      count_d = count_q + FIFO_ONE;
    end else if (pop_s && !wr_en_s) begin
      count_d = count_q - FIFO_ONE;
    end else begin
      count_d = count_q;
    end
    rx_valid_d  = (count_d != {(AW + 1){1'b0}});
    ferr_d      = ferr_set_s | (ferr_q & ~err_clr);
    perr_flag_d = (rx_push_q & rx_perr_q) | (perr_flag_q & ~err_clr);
    ovr_d       = ovr_set_s | (ovr_q & ~err_clr);
  end

  // State registers for both FSMs, the synchronizer, FIFO and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= CNT_ZERO;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= {DATA_BITS{1'b0}};
      tx_par_q    <= 1'b0;
      tx_line_q   <= 1'b1;
      tx_ready_q  <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= CNT_ZERO;
      rx_bit_q    <= 4'd0;
      rx_shift_q  <= {DATA_BITS{1'b0}};
      rx_perr_q   <= 1'b0;
      rx_push_q   <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {(AW + 1){1'b0}};
      rx_valid_q  <= 1'b0;
      ferr_q      <= 1'b0;
      perr_flag_q <= 1'b0;
      ovr_q       <= 1'b0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
        fifo_q[i] <= {DATA_BITS{1'b0}};
      end
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_line_q   <= tx_line_d;
      tx_ready_q  <= tx_ready_d;
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_perr_q   <= rx_perr_d;
      rx_push_q   <= rx_push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_valid_q  <= rx_valid_d;
      ferr_q      <= ferr_d;
      perr_flag_q <= perr_flag_d;
      ovr_q       <= ovr_d;
      if (wr_en_s) begin
        fifo_q[wr_ptr_q] <= rx_shift_q;
      end else begin
        fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
      end
    end
  end

  assign uart_tx       = tx_line_q;
  assign tx_ready      = tx_ready_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = fifo_q[rd_ptr_q];
  assign rx_count      = count_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_flag_q;
  assign rx_overrun    = ovr_q;

endmodule
